// File: rtl/alu_sequencer_if.sv
// Instruction and ALU bundle between the sequencer and its surroundings.
// Latency: none; this interface only groups wires.
// Backpressure: instr_valid/instr_ready handshake; the ALU side has no flow control.
// Ports:
//   instr_valid, instr, instr_ready                : instruction offer and accept
//   alu_opcode, alu_func3, alu_func7, alu_a, alu_b : decoded fields and operands to the ALU
//   alu_out                                        : registered ALU result back to the sequencer
//   done, illegal, wb_rd, wb_data                  : retire status and last write-back
// Modports: slave = sequencer side, master = instruction source plus ALU side.
interface alu_sequencer_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_func3;
    logic [6:0]  alu_func7;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic        done;
    logic        illegal;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    modport slave (
        input  instr_valid, instr, alu_out,
        output instr_ready, alu_opcode, alu_func3, alu_func7, alu_a, alu_b,
               done, illegal, wb_rd, wb_data
    );

    modport master (
        output instr_valid, instr, alu_out,
        input  instr_ready, alu_opcode, alu_func3, alu_func7, alu_a, alu_b,
               done, illegal, wb_rd, wb_data
    );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences RV32 ADDI/ADD/SUB through an external registered ALU with a 32x32 register file.
// Latency: done is high 3 cycles after the accepting edge; one instruction every 4 cycles.
// Backpressure: instr_ready is high only in IDLE, so a held instr_valid waits 3 cycles between accepts.
// Ports: clk, rst_n (async active-low), bus (alu_sequencer_if.slave),
//        retire_cnt (16-bit retired-instruction count, only with ALU_SEQ_RETIRE_CNT_EN defined).
// Build option: define ALU_SEQ_RETIRE_CNT_EN to add the retire_cnt output and its counter.
module alu_sequencer (
    input  logic clk,
    input  logic rst_n,
    alu_sequencer_if.slave bus
`ifdef ALU_SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0] retire_cnt
`endif
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_ADD     = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] instr_q;
    logic [31:0] rf [32];

    logic        instr_ld;
    logic        alu_ld;
    logic        rf_we;
    logic        ready_c;
    logic        done_c;
    logic        illegal_c;

    // Field decode straight from the captured instruction word.
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm_i;
    logic        is_op_imm;
    logic        is_op;
    logic        legal;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign func3  = instr_q[14:12];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign func7  = instr_q[31:25];
    assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};

    assign is_op_imm = (opcode == OPC_OP_IMM) && (func3 == 3'b000);
    assign is_op     = (opcode == OPC_OP) && (func3 == 3'b000) &&
                       ((func7 == F7_ADD) || (func7 == F7_SUB));
    assign legal     = is_op_imm || is_op;

    // x0 is forced to zero on read; it is also never written.
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ready_c   = 1'b0;
        done_c    = 1'b0;
        illegal_c = 1'b0;
        instr_ld  = 1'b0;
        alu_ld    = 1'b0;
        rf_we     = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.instr_valid) begin
                    instr_ld = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                if (legal) begin
                    alu_ld  = 1'b1;
                    state_d = EXEC;
                end else begin
                    illegal_c = 1'b1;
                    state_d   = IDLE;
                end
            end
            EXEC: begin
                state_d = WB;
            end
            WB: begin
                done_c  = 1'b1;
                rf_we   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.instr_ready = ready_c;
    assign bus.done        = done_c;
    assign bus.illegal     = illegal_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
        end else if (instr_ld) begin
            instr_q <= bus.instr;
        end
    end

    // ALU drive is loaded on the edge into EXEC, so it is stable for all of
    // EXEC and simply holds afterwards until the next legal instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_opcode <= '0;
            bus.alu_func3  <= '0;
            bus.alu_func7  <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
        end else if (alu_ld) begin
            bus.alu_opcode <= opcode;
            bus.alu_func3  <= func3;
            bus.alu_func7  <= func7;
            bus.alu_a      <= rs1_val;
            bus.alu_b      <= is_op ? rs2_val : imm_i;
        end
    end

    // alu_out was registered by the ALU on the edge into WB, so it is valid
    // throughout WB and is committed on the edge leaving WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wb_rd   <= '0;
            bus.wb_data <= '0;
        end else if (rf_we) begin
            bus.wb_rd   <= rd;
            bus.wb_data <= bus.alu_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (rf_we && (rd == 5'(i))) begin
                    rf[i] <= bus.alu_out;
                end
            end
        end
    end

`ifdef ALU_SEQ_RETIRE_CNT_EN
    // Counts done pulses only; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= '0;
        end else if (rf_we) begin
            retire_cnt <= retire_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a registered add/sub ALU model on the bus.
// Latency: not applicable.
// Backpressure: the bench waits on instr_ready and holds instr_valid in one scenario.
module tb_alu_sequencer;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    alu_sequencer_if ifc();

`ifdef ALU_SEQ_RETIRE_CNT_EN
    logic [15:0] retire_cnt;
    int          exp_retire;
`endif

    alu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
`ifdef ALU_SEQ_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: SUB for R-type with func7 0100000, ADD otherwise, registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifc.alu_out <= '0;
        end else if (ifc.alu_opcode == 7'b0110011 && ifc.alu_func7 == 7'b0100000) begin
            ifc.alu_out <= ifc.alu_a - ifc.alu_b;
        end else begin
            ifc.alu_out <= ifc.alu_a + ifc.alu_b;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one legal instruction and follow it through DECODE/EXEC/WB to IDLE.
    task automatic exec_instr(input string tag, input logic [31:0] w,
                              input logic [31:0] exp_a, input logic [31:0] exp_b,
                              input logic [4:0] exp_rd, input logic [31:0] exp_data);
        @(negedge clk);
        chk({tag, ".ready"}, 32'(ifc.instr_ready), 32'd1);
        ifc.instr_valid = 1'b1;
        ifc.instr       = w;
        @(posedge clk);
        #1;
        ifc.instr_valid = 1'b0;
        @(negedge clk);                       // DECODE
        chk({tag, ".dec_done"}, 32'(ifc.done), 32'd0);
        chk({tag, ".dec_ill"}, 32'(ifc.illegal), 32'd0);
        @(negedge clk);                       // EXEC
        chk({tag, ".a"}, ifc.alu_a, exp_a);
        chk({tag, ".b"}, ifc.alu_b, exp_b);
        chk({tag, ".opc"}, 32'(ifc.alu_opcode), 32'(w[6:0]));
        chk({tag, ".f7"}, 32'(ifc.alu_func7), 32'(w[31:25]));
        chk({tag, ".ex_done"}, 32'(ifc.done), 32'd0);
        @(negedge clk);                       // WB
        chk({tag, ".wb_done"}, 32'(ifc.done), 32'd1);
        chk({tag, ".wb_rdy"}, 32'(ifc.instr_ready), 32'd0);
        @(negedge clk);                       // back in IDLE
        chk({tag, ".rd"}, 32'(ifc.wb_rd), 32'(exp_rd));
        chk({tag, ".data"}, ifc.wb_data, exp_data);
        chk({tag, ".idle_done"}, 32'(ifc.done), 32'd0);
        chk({tag, ".hold_b"}, ifc.alu_b, exp_b);
`ifdef ALU_SEQ_RETIRE_CNT_EN
        exp_retire++;
        chk({tag, ".retire"}, 32'(retire_cnt), 32'(exp_retire));
`endif
    endtask

    task automatic bad_instr(input string tag, input logic [31:0] w);
        @(negedge clk);
        chk({tag, ".ready"}, 32'(ifc.instr_ready), 32'd1);
        ifc.instr_valid = 1'b1;
        ifc.instr       = w;
        @(posedge clk);
        #1;
        ifc.instr_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".ill"}, 32'(ifc.illegal), 32'd1);
        chk({tag, ".done"}, 32'(ifc.done), 32'd0);
        @(negedge clk);
        chk({tag, ".ill_off"}, 32'(ifc.illegal), 32'd0);
        chk({tag, ".rdy_back"}, 32'(ifc.instr_ready), 32'd1);
`ifdef ALU_SEQ_RETIRE_CNT_EN
        chk({tag, ".retire"}, 32'(retire_cnt), 32'(exp_retire));
`endif
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, ".rdy"}, 32'(ifc.instr_ready), 32'd1);
        chk({tag, ".done"}, 32'(ifc.done), 32'd0);
        chk({tag, ".ill"}, 32'(ifc.illegal), 32'd0);
        chk({tag, ".a"}, ifc.alu_a, 32'd0);
        chk({tag, ".b"}, ifc.alu_b, 32'd0);
        chk({tag, ".opc"}, 32'(ifc.alu_opcode), 32'd0);
        chk({tag, ".wb_rd"}, 32'(ifc.wb_rd), 32'd0);
        chk({tag, ".wb_data"}, ifc.wb_data, 32'd0);
`ifdef ALU_SEQ_RETIRE_CNT_EN
        chk({tag, ".retire"}, 32'(retire_cnt), 32'd0);
`endif
    endtask

    initial begin
        int accepts;
        int low;
        int dones;
        int cyc;

        total = 0;
        bad   = 0;
`ifdef ALU_SEQ_RETIRE_CNT_EN
        exp_retire = 0;
`endif
        rst_n           = 1'b0;
        ifc.instr_valid = 1'b0;
        ifc.instr       = '0;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        exec_instr("addi_x1", 32'h00500093, 32'h0, 32'h5, 5'd1, 32'h5);
        exec_instr("addi_x2", 32'h00700113, 32'h0, 32'h7, 5'd2, 32'h7);
        exec_instr("add_x3", 32'h002081B3, 32'h5, 32'h7, 5'd3, 32'hC);
        exec_instr("sub_x4", 32'h40208233, 32'h5, 32'h7, 5'd4, 32'hFFFFFFFE);
        exec_instr("addi_neg", 32'hFFF00293, 32'h0, 32'hFFFFFFFF, 5'd5, 32'hFFFFFFFF);
        exec_instr("add_x0", 32'h00208033, 32'h5, 32'h7, 5'd0, 32'hC);
        exec_instr("rd_x0", 32'h005003B3, 32'h0, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFF);

        bad_instr("load", 32'h00002003);
        bad_instr("slli", 32'h00109093);
        bad_instr("mul", 32'h02208033);
        // x1 and x3 untouched by the rejected words.
        exec_instr("after_ill", 32'h00308433, 32'h5, 32'hC, 5'd8, 32'h11);

        // Hold instr_valid high across two instructions.
        accepts = 0;
        low     = 0;
        dones   = 0;
        cyc     = 0;
        @(negedge clk);
        ifc.instr_valid = 1'b1;
        ifc.instr       = 32'h00100493;
        while (accepts < 2 && cyc < 40) begin
            cyc++;
            if (ifc.instr_ready) begin
                accepts++;
                if (accepts == 2) begin
                    chk("stream.gap", 32'(low), 32'd3);
                end
                low = 0;
                @(posedge clk);
                #1;
                if (accepts == 1) begin
                    ifc.instr = 32'h00200513;
                end else begin
                    ifc.instr_valid = 1'b0;
                end
            end else begin
                low++;
                if (ifc.done) dones++;
            end
            @(negedge clk);
        end
        chk("stream.accepts", 32'(accepts), 32'd2);
        // Loop ended at the DECODE cycle of the second word.
        for (int i = 0; i < 3; i++) begin
            if (ifc.done) dones++;
            @(negedge clk);
        end
        chk("stream.dones", 32'(dones), 32'd2);
        chk("stream.rd", 32'(ifc.wb_rd), 32'd10);
        chk("stream.data", ifc.wb_data, 32'd2);
`ifdef ALU_SEQ_RETIRE_CNT_EN
        exp_retire += 2;
`endif
        exec_instr("stream_chk", 32'h00A485B3, 32'h1, 32'h2, 5'd11, 32'h3);

        // Reset in the middle of EXEC of addi x1,x0,5.
        @(negedge clk);
        ifc.instr_valid = 1'b1;
        ifc.instr       = 32'h00500093;
        @(posedge clk);
        #1;
        ifc.instr_valid = 1'b0;
        @(negedge clk);                       // DECODE
        @(negedge clk);                       // EXEC
        chk("rst.exec_b", ifc.alu_b, 32'h5);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("rst_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
`ifdef ALU_SEQ_RETIRE_CNT_EN
        exp_retire = 0;
`endif
        exec_instr("rst_x1", 32'h00008633, 32'h0, 32'h0, 5'd12, 32'h0);
        exec_instr("rst_x3", 32'h00018693, 32'h0, 32'h0, 5'd13, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have no parameters; register file is fixed at 32 x 32-bit.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 instr_valid  input  1  instruction word offered.
REQ-005 instr  input  32  RV32 instruction word.
REQ-006 instr_ready  output  1  sequencer can accept; transfer on instr_valid & instr_ready at rising edge.
REQ-007 alu_opcode / alu_func3 / alu_func7  output  7/3/7  decoded fields driven to external ALU.
REQ-008 alu_a / alu_b  output  32/32  ALU operands.
REQ-009 alu_out  input  32  ALU result, registered inside ALU on clk.
REQ-010 done  output  1  one-cycle pulse, legal instruction retired.
REQ-011 illegal  output  1  one-cycle pulse, instruction rejected.
REQ-012 wb_rd / wb_data  output  5/32  destination index and value of last retired instruction.

Function
REQ-013 FSM states SHALL be IDLE, DECODE, EXEC, WB; instr_ready=1 only in IDLE.
REQ-014 IDLE -> DECODE on handshake; instr captured into internal register; otherwise stay IDLE.
REQ-015 DECODE: rd=instr[11:7], rs1=[19:15], rs2=[24:20], func3=[14:12], func7=[31:25], opcode=[6:0]; I-type imm = sign-extended instr[31:20].
REQ-016 Legal: (opcode 0010011, func3 000) or (opcode 0110011, func3 000, func7 0000000 or 0100000); all else illegal.
REQ-017 DECODE -> EXEC if legal; DECODE -> IDLE with illegal=1 for that cycle if illegal; no register write.
REQ-018 EXEC: alu_a=RF[rs1], alu_b=RF[rs2] (R-type) or imm (I-type), decoded fields on alu_*; outputs registered, stable for whole EXEC cycle; EXEC -> WB unconditionally.
REQ-019 WB: RF[rd]<=alu_out at edge leaving WB; wb_rd/wb_data updated same edge; done=1 during WB; WB -> IDLE.
REQ-020 Latency: handshake edge to done asserted = 3 cycles; throughput one instruction per 4 cycles.
REQ-021 RF[0] SHALL read 0 always; writes to rd=0 discarded, done still pulses, wb_rd=0, wb_data=alu_out.
REQ-022 Arithmetic 32-bit, overflow wraps, no flags.
REQ-023 rs1 or rs2 equal to rd of preceding instruction SHALL read the written-back value (write completes before next DECODE).
REQ-024 alu_* outputs SHALL hold last value outside EXEC.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, instr_ready=1 after release, done=0, illegal=0, alu_*=0, wb_rd=0, wb_data=0, all RF entries 0.
REQ-026 Reset mid-instruction SHALL abandon it with no register write; first post-reset handshake starts clean.

Configuration
REQ-027 Macro ALU_SEQ_RETIRE_CNT_EN defined: extra output retire_cnt (16-bit), reset 0, +1 on each done pulse, wraps 0xFFFF -> 0x0000, illegal not counted.
REQ-028 Macro undefined: retire_cnt port and counter absent; all other behaviour identical.

Verification
REQ-029 Reset, then 0x00500093 (addi x1,x0,5) -> done 3 cycles after handshake, wb_rd=1, wb_data=0x00000005, alu_b=0x00000005 during EXEC.
REQ-030 Then 0x00700113, 0x002081B3 (add x3,x1,x2) -> wb_rd=3, wb_data=0x0000000C; then 0x40208233 (sub x4) -> wb_data=0xFFFFFFFE.
REQ-031 0xFFF00293 (addi x5,x0,-1) -> alu_b=0xFFFFFFFF, wb_data=0xFFFFFFFF; then 0x00208033 (add x0) -> done=1, later rs1=x0 reads 0.
REQ-032 0x00002003 (load opcode) -> illegal pulse 1 cycle after handshake, no done, RF unchanged, instr_ready=1 next cycle.
REQ-033 instr_valid held high continuously -> instr_ready low for 3 cycles between accepts, no instruction dropped or duplicated.
REQ-034 rst_n asserted during EXEC of 0x00500093 -> outputs zero immediately, x1 reads 0 afterwards; with ALU_SEQ_RETIRE_CNT_EN, retire_cnt=0 then +1 per retired instruction.
